branch_predict_tables: RTL and testbench

// - Fetch-stage bimodal predictor: branch-target buffer (BTB), 2-bit pattern history table (PHT), branch/jump classifier.
// - Looks up the fetch PC combinationally and predicts direction and target for branches and jumps.
// - Trains from the instruction resolving in MEM; sits beside the PC-select mux in IF.

---
 rtl/branch_predict_tables_pkg.sv | 34 +++
 rtl/branch_predict_tables_if.sv | 29 ++
 rtl/branch_predict_tables_decode.sv | 34 +++
 rtl/branch_predict_tables.sv | 85 ++++++++
 tb/tb_branch_predict_tables.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/branch_predict_tables_pkg.sv
// bp_pkg: shared constants and helpers for the fetch-stage bimodal predictor.
//   - MIPS-I opcode / funct / rt field values used by the branch/jump classifier
//   - ctr2_t: 2-bit saturating pattern-history counter
//   - sat_inc / sat_dec: saturating counter update helpers
package bp_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;
    localparam logic [4:0] RT_BLTZAL  = 5'b10000;
    localparam logic [4:0] RT_BGEZAL  = 5'b10001;

    typedef logic [1:0] ctr2_t;

    function automatic ctr2_t sat_inc(input ctr2_t c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic ctr2_t sat_dec(input ctr2_t c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/branch_predict_tables_if.sv
// branch_predict_tables_if: fetch lookup + MEM training bundle for the predictor.
//   master: drives FLUSH, fetch instruction/PC and the MEM resolution inputs
//   slave : the predictor; returns Taken_OUT, Taken_Addr_OUT, Is_Branch_OUT
interface branch_predict_tables_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              FLUSH;
    logic [31:0]       Instr_IN;
    logic [ADDR_W-1:0] Instr_Addr_IN;
    logic [31:0]       Upd_Instr_IN;
    logic [ADDR_W-1:0] Upd_PC_IN;
    logic              Upd_Taken_IN;
    logic [ADDR_W-1:0] Upd_Target_IN;
    logic              Taken_OUT;
    logic [ADDR_W-1:0] Taken_Addr_OUT;
    logic              Is_Branch_OUT;

    modport master (
        output FLUSH, Instr_IN, Instr_Addr_IN,
               Upd_Instr_IN, Upd_PC_IN, Upd_Taken_IN, Upd_Target_IN,
        input  Taken_OUT, Taken_Addr_OUT, Is_Branch_OUT
    );

    modport slave (
        input  FLUSH, Instr_IN, Instr_Addr_IN,
               Upd_Instr_IN, Upd_PC_IN, Upd_Taken_IN, Upd_Target_IN,
        output Taken_OUT, Taken_Addr_OUT, Is_Branch_OUT
    );
endinterface

// File: rtl/branch_predict_tables_decode.sv
// branch_class_decode: MIPS-I branch / jump classifier (pure combinational).
//   instr  in  32  instruction word
//   branch out 1   conditional branch (beq/bne/blez/bgtz, regimm bltz/bgez/bltzal/bgezal)
//   jump   out 1   j/jal, or special jr/jalr
module branch_class_decode
    import bp_pkg::*;
(
    input  logic [31:0] instr,
    output logic        branch,
    output logic        jump
);
    logic [5:0] opcode;
    logic [4:0] rt;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode = instr[31:26];
    assign rt     = instr[20:16];
    assign funct  = instr[5:0];
    assign unused_fields = ^{instr[25:21], instr[15:6]};

    always_comb begin
        branch = 1'b0;
        jump   = 1'b0;
        case (opcode)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: branch = 1'b1;
            OP_REGIMM:  branch = (rt == RT_BLTZ) || (rt == RT_BGEZ) ||
                                 (rt == RT_BLTZAL) || (rt == RT_BGEZAL);
            OP_J, OP_JAL: jump = 1'b1;
            OP_SPECIAL: jump = (funct == FN_JR) || (funct == FN_JALR);
            default: ;
        endcase
    end
endmodule

// File: rtl/branch_predict_tables.sv
// branch_predict_tables: fetch-stage bimodal predictor (direct-mapped BTB + 2-bit PHT).
//   CLK    in  clock, all table updates on rising edge
//   RESET  in  asynchronous active-high reset; clears BTB valid, PHT <= PHT_INIT
//   bp     slave port of branch_predict_tables_if:
//            fetch lookup (Instr_IN/Instr_Addr_IN -> Taken_OUT/Taken_Addr_OUT/Is_Branch_OUT),
//            MEM training (Upd_*), FLUSH zeroes predictions but never blocks training.
module branch_predict_tables
    import bp_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned BTB_ENTRIES = 64,
    parameter int unsigned PHT_ENTRIES = 1024,
    parameter ctr2_t       PHT_INIT    = 2'b01
) (
    input  logic                   CLK,
    input  logic                   RESET,
    branch_predict_tables_if.slave bp
);
    localparam int unsigned BTB_IW = $clog2(BTB_ENTRIES);
    localparam int unsigned PHT_IW = $clog2(PHT_ENTRIES);
    localparam int unsigned TAG_W  = ADDR_W - BTB_IW - 2;

    logic              btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0]  btb_tag    [BTB_ENTRIES];
    logic [ADDR_W-1:0] btb_target [BTB_ENTRIES];
    ctr2_t             pht        [PHT_ENTRIES];

    logic f_br, f_jmp, f_isbr;
    logic u_br, u_jmp, u_isbr;

    branch_class_decode u_dec_fetch (.instr(bp.Instr_IN),     .branch(f_br), .jump(f_jmp));
    branch_class_decode u_dec_mem   (.instr(bp.Upd_Instr_IN), .branch(u_br), .jump(u_jmp));

    assign f_isbr = f_br | f_jmp;
    assign u_isbr = u_br | u_jmp;

    logic [BTB_IW-1:0] f_bidx, u_bidx;
    logic [PHT_IW-1:0] f_pidx, u_pidx;
    logic [TAG_W-1:0]  f_tag,  u_tag;
    logic              unused_pc_lsbs;

    assign f_bidx = bp.Instr_Addr_IN[BTB_IW+1:2];
    assign f_pidx = bp.Instr_Addr_IN[PHT_IW+1:2];
    assign f_tag  = bp.Instr_Addr_IN[ADDR_W-1:BTB_IW+2];
    assign u_bidx = bp.Upd_PC_IN[BTB_IW+1:2];
    assign u_pidx = bp.Upd_PC_IN[PHT_IW+1:2];
    assign u_tag  = bp.Upd_PC_IN[ADDR_W-1:BTB_IW+2];
    assign unused_pc_lsbs = ^{bp.Instr_Addr_IN[1:0], bp.Upd_PC_IN[1:0]};

    // Lookup reads pre-edge table contents; no bypass from a same-cycle update.
    logic hit;
    always_comb begin
        hit               = btb_valid[f_bidx] && (btb_tag[f_bidx] == f_tag);
        bp.Taken_OUT      = 1'b0;
        bp.Taken_Addr_OUT = '0;
        if (!RESET && !bp.FLUSH && f_isbr && hit) begin
            bp.Taken_OUT      = pht[f_pidx][1];
            bp.Taken_Addr_OUT = btb_target[f_bidx];
        end
    end

    assign bp.Is_Branch_OUT = f_isbr;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            btb_valid <= '{default: 1'b0};
            pht       <= '{default: PHT_INIT};
        end else if (u_isbr) begin
            if (bp.Upd_Taken_IN) begin
                btb_valid[u_bidx] <= 1'b1;
                pht[u_pidx]       <= sat_inc(pht[u_pidx]);
            end else begin
                pht[u_pidx]       <= sat_dec(pht[u_pidx]);
            end
        end
    end

    // Tag/target need no reset: they are only observed through a set valid bit.
    always_ff @(posedge CLK) begin
        if (!RESET && u_isbr && bp.Upd_Taken_IN) begin
            btb_tag[u_bidx]    <= u_tag;
            btb_target[u_bidx] <= bp.Upd_Target_IN;
        end
    end
endmodule

// File: tb/tb_branch_predict_tables.sv
// tb_branch_predict_tables: directed self-checking bench for branch_predict_tables.
module tb_branch_predict_tables;

    localparam logic [31:0] BEQ   = 32'h1000_0003;
    localparam logic [31:0] ADD   = 32'h0085_1020;
    localparam logic [31:0] JR31  = 32'h03E0_0008;
    localparam logic [31:0] PC_A  = 32'h0040_0100;
    localparam logic [31:0] TGT_A = 32'h0040_0110;
    localparam logic [31:0] PC_AL = 32'h0040_0200;   // PC_A + 4*64: same BTB index, other tag
    localparam logic [31:0] PC_J  = 32'h0040_0040;
    localparam logic [31:0] TGT_J = 32'h0040_0200;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 CLK = ~CLK;

    branch_predict_tables_if #(.ADDR_W(32)) bp_if ();

    branch_predict_tables #(
        .ADDR_W(32), .BTB_ENTRIES(64), .PHT_ENTRIES(1024), .PHT_INIT(2'b01)
    ) dut (
        .CLK(CLK), .RESET(RESET), .bp(bp_if)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] instr, input logic [31:0] pc);
        bp_if.Instr_IN      = instr;
        bp_if.Instr_Addr_IN = pc;
        #1;
    endtask

    task automatic expect_pred(input string tag, input logic tk, input logic [31:0] addr);
        check_val({tag, "_taken"}, {31'd0, bp_if.Taken_OUT}, {31'd0, tk});
        check_val({tag, "_addr"},  bp_if.Taken_Addr_OUT, addr);
    endtask

    task automatic upd(input logic [31:0] instr, input logic [31:0] pc,
                       input logic taken, input logic [31:0] tgt);
        bp_if.Upd_Instr_IN  = instr;
        bp_if.Upd_PC_IN     = pc;
        bp_if.Upd_Taken_IN  = taken;
        bp_if.Upd_Target_IN = tgt;
        @(posedge CLK);
        #1;
        bp_if.Upd_Instr_IN  = 32'h0;
        bp_if.Upd_Taken_IN  = 1'b0;
    endtask

    // Classifier vectors: instruction, expected Is_Branch_OUT.
    logic [31:0] cls_instr [8] = '{32'h0810_0000, 32'h0C10_0000, 32'h0401_0005, 32'h0402_0005,
                                   32'h0000_F809, 32'h0085_1020, 32'h1C20_0004, 32'h8C82_0000};
    logic        cls_exp   [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        bp_if.FLUSH         = 1'b0;
        bp_if.Instr_IN      = 32'h0;
        bp_if.Instr_Addr_IN = 32'h0;
        bp_if.Upd_Instr_IN  = 32'h0;
        bp_if.Upd_PC_IN     = 32'h0;
        bp_if.Upd_Taken_IN  = 1'b0;
        bp_if.Upd_Target_IN = 32'h0;

        #2 RESET = 1'b1;
        fetch(BEQ, PC_A);
        expect_pred("in_reset", 1'b0, 32'h0);
        check_val("in_reset_isbr", {31'd0, bp_if.Is_Branch_OUT}, 32'd1);
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        fetch(BEQ, PC_A);
        expect_pred("post_reset", 1'b0, 32'h0);
        check_val("post_reset_isbr", {31'd0, bp_if.Is_Branch_OUT}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            fetch(cls_instr[i], PC_A);
            check_val($sformatf("class_%0d", i), {31'd0, bp_if.Is_Branch_OUT}, {31'd0, cls_exp[i]});
        end

        // Train once: 01 -> 10
        upd(BEQ, PC_A, 1'b1, TGT_A);
        fetch(BEQ, PC_A);
        expect_pred("train1", 1'b1, TGT_A);

        // Saturation: 4 taken -> 11, 1 not-taken -> 10
        repeat (4) upd(BEQ, PC_A, 1'b1, TGT_A);
        upd(BEQ, PC_A, 1'b0, 32'h0);
        fetch(BEQ, PC_A);
        expect_pred("sat_hi_nt1", 1'b1, TGT_A);
        repeat (2) upd(BEQ, PC_A, 1'b0, 32'h0);
        fetch(BEQ, PC_A);
        expect_pred("sat_00", 1'b0, TGT_A);
        // Extra not-taken stays at 00, so one taken reaches only 01
        upd(BEQ, PC_A, 1'b0, 32'h0);
        upd(BEQ, PC_A, 1'b1, TGT_A);
        fetch(BEQ, PC_A);
        expect_pred("sat_lo_t1", 1'b0, TGT_A);
        upd(BEQ, PC_A, 1'b1, TGT_A);
        fetch(BEQ, PC_A);
        expect_pred("sat_lo_t2", 1'b1, TGT_A);

        // Alias: same BTB index, different tag -> miss
        fetch(BEQ, PC_AL);
        expect_pred("alias", 1'b0, 32'h0);

        // Non-branch MEM instr must not train (counter stays 10)
        upd(ADD, PC_A, 1'b1, 32'h0040_0300);
        repeat (2) upd(ADD, PC_A, 1'b0, 32'h0);
        fetch(BEQ, PC_A);
        expect_pred("nonbr_filter", 1'b1, TGT_A);

        // FLUSH zeroes predictions, keeps decode
        bp_if.FLUSH = 1'b1;
        fetch(BEQ, PC_A);
        expect_pred("flush", 1'b0, 32'h0);
        check_val("flush_isbr", {31'd0, bp_if.Is_Branch_OUT}, 32'd1);
        // FLUSH does not block training: 10 -> 01
        upd(BEQ, PC_A, 1'b0, 32'h0);
        bp_if.FLUSH = 1'b0;
        fetch(BEQ, PC_A);
        expect_pred("flush_upd", 1'b0, TGT_A);

        // Same-cycle update/lookup: pre-edge counter 01 seen, then 10
        bp_if.Upd_Instr_IN  = BEQ;
        bp_if.Upd_PC_IN     = PC_A;
        bp_if.Upd_Taken_IN  = 1'b1;
        bp_if.Upd_Target_IN = TGT_A;
        fetch(BEQ, PC_A);
        expect_pred("nobypass_pre", 1'b0, TGT_A);
        @(posedge CLK);
        #1;
        bp_if.Upd_Instr_IN = 32'h0;
        bp_if.Upd_Taken_IN = 1'b0;
        fetch(BEQ, PC_A);
        expect_pred("nobypass_post", 1'b1, TGT_A);

        // Jump: jr $31 trained twice
        fetch(JR31, PC_J);
        expect_pred("jr_cold", 1'b0, 32'h0);
        repeat (2) upd(JR31, PC_J, 1'b1, TGT_J);
        fetch(JR31, PC_J);
        expect_pred("jr_trained", 1'b1, TGT_J);

        // Asynchronous reset between clock edges clears tables without a clock
        RESET = 1'b1;
        #1;
        expect_pred("async_rst_out", 1'b0, 32'h0);
        RESET = 1'b0;
        fetch(JR31, PC_J);
        expect_pred("async_rst_jr", 1'b0, 32'h0);
        fetch(BEQ, PC_A);
        expect_pred("async_rst_beq", 1'b0, 32'h0);
        // Counter back at 01: one taken -> 10
        upd(JR31, PC_J, 1'b1, TGT_J);
        fetch(JR31, PC_J);
        expect_pred("post_rst_train", 1'b1, TGT_J);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
